ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- NeoPixel (WS2812B) line decoder for the single-wire GRB serial stream.
- Oversamples the data line, measures each high pulse and turns it into bits, then assembles 24-bit GRB pixels and presents them as R/G/B bytes with an LED address.
- Detects the low-level reset gap and reports frame completion with a pixel count.
- Used as a loopback checker and as a capture front-end for an upstream pixel source.

Parameters:
- NUM_LEDS, 8: maximum pixels captured per frame.
- SYSTEM_CLOCK, 50_000_000: clk_i frequency in Hz; all timing thresholds derive from it.
- RESET_US, 50: minimum low time (µs) treated as the frame reset gap.
- Derived localparams, values at defaults:
  - BIT_CYCLES = SYSTEM_CLOCK/800_000 (62)
  - THRESH = 0.45*BIT_CYCLES (27)
  - MIN_HIGH = BIT_CYCLES/8 (7)
  - MAX_HIGH = 0.85*BIT_CYCLES (52)
  - RESET_COUNT = SYSTEM_CLOCK/1_000_000*RESET_US (2500)

Ports:
- clk_i  in  1  system clock; single clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  decoder enable; low forces the SYNC state.
- di_i  in  1  NeoPixel data line; asynchronous to clk_i, passed through a 2-flop synchronizer.
- busy_o  out  1  high while the state is HIGH or LOW (mid-frame).
- pixel_valid_o  out  1  one-cycle strobe; a new pixel is on red_o/green_o/blue_o/address_o.
- address_o  out  $clog2(NUM_LEDS)  index of the presented pixel, 0-based.
- red_o, green_o, blue_o  out  8 each  decoded colour bytes.
- frame_done_o  out  1  one-cycle strobe at the end of the reset gap.
- pixel_count_o  out  $clog2(NUM_LEDS+1)  complete pixels in the last frame; saturates at NUM_LEDS.
- error_o  out  1  one-cycle timing-error strobe; tied 0 without WS2812_RX_ERR_EN.

Behaviour:
- Reset values: all outputs 0; state SYNC; all counters 0.
- Edge detection: s = synchronizer output, p = s delayed one cycle. Rise = s & ~p; fall = ~s & p.
- SYNC:
  - Counts consecutive low cycles of s; any high clears the count.
  - Count reaching RESET_COUNT-1 -> READY.
  - No decoding happens in SYNC. This prevents locking on mid-frame.
- READY: rise -> HIGH with high counter = 1; bit count and address already 0.
- HIGH:
  - High counter increments each cycle.
  - On fall, the bit is classified: 1 if count >= THRESH, else 0. Bit is shifted MSB-first into a 24-bit register, bit count increments, state -> LOW with low counter = 1.
  - If the high counter reaches RESET_COUNT (stuck high) -> SYNC and the partial pixel is discarded.
- Pixel assembly:
  - When the 24th bit is classified, the next cycle drives green_o = bits[23:16], red_o = [15:8], blue_o = [7:0], pixel_valid_o = 1, address_o = current index.
  - The address then increments and the bit count returns to 0.
  - Latency: pixel_valid_o is high 4 clocks after di_i falls on the last bit (2 sync + edge + register).
- Overflow: pixels with index >= NUM_LEDS are decoded but give no strobe. Colour and address outputs are unchanged, and address_o holds NUM_LEDS-1.
- LOW:
  - Low counter increments.
  - Rise -> HIGH.
  - Low counter reaching RESET_COUNT-1 ends the frame:
    - frame_done_o = 1 for one cycle, only if at least one bit was seen in the frame.
    - pixel_count_o is updated in the same cycle to the number of complete pixels, min(n, NUM_LEDS).
    - A partial pixel (bit count != 0) is dropped.
    - Address and bit count clear; state -> READY.
- Colour outputs and pixel_count_o hold their values between strobes.
- enable_i low: forced to SYNC next cycle. Counters clear, no strobes, other outputs hold. After re-enable a full reset gap is required before decoding.
- reset_i mid-frame: immediate return to reset values; the frame is lost.

Optional Feature:
WS2812_RX_ERR_EN
- Defined, error_o pulses one cycle in each of these cases:
  - High pulse < MIN_HIGH: the glitch is not counted as a bit; state -> LOW.
  - High pulse > MAX_HIGH but below RESET_COUNT: bit discarded, partial pixel dropped, state -> SYNC.
  - Stuck high.
  - Frame ending with a partial pixel: error_o is coincident with frame_done_o.
- Undefined:
  - error_o is constant 0.
  - Short pulses classify as 0 and long pulses as 1.
  - Only stuck-high returns the block to SYNC.

Test Plan:
- 60 µs low, then 3 pixels G=0x12 R=0x34 B=0x56, 0x00/0xFF/0x80, 0xA5/0x5A/0x0F (H0=18 / H1=37 of 59-cycle bits), then 60 µs low -> 3 pixel_valid_o strobes:
  - addresses 0, 1, 2
  - red_o = 0x34, 0xFF, 0x5A
  - one frame_done_o with pixel_count_o = 3
- enable_i rises mid-frame after 100 bits -> no pixel_valid_o until a 50 µs gap occurs; the next frame decodes from address 0.
- 10 pixels with NUM_LEDS = 8 -> 8 strobes (addresses 0–7), pixel_count_o = 8, address_o holds 7.
- 30 bits then a gap -> one pixel strobe, frame_done_o with pixel_count_o = 1; with ERR_EN, error_o coincident with frame_done_o.
- ERR_EN: 4-cycle glitch inside a byte -> error_o pulse, no bit shifted; a 55-cycle high -> error_o, then no strobes until a fresh gap.
- di_i held high for 3000 cycles -> state SYNC, busy_o = 0, no strobes; a later valid frame decodes correctly.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx -- WS2812B (NeoPixel) single-wire GRB stream decoder.
//
// The data line is oversampled on clk_i. Each high pulse is timed and
// classified as a 0 or a 1. Bits are packed MSB-first into 24-bit GRB pixels,
// which are presented as R/G/B bytes with a pixel address. A long low level
// (the reset gap) ends the frame and reports how many complete pixels arrived.
//
// Optional feature macro: WS2812_RX_ERR_EN
//   When defined, high pulses that are too short or too long, a stuck-high
//   line, and a frame that ends with a partial pixel all pulse error_o.
//   When undefined, error_o is tied to 0, pulse width only chooses 0 or 1,
//   and only a stuck-high line forces a resynchronisation.
//
// Ports:
//   clk_i          system clock (SYSTEM_CLOCK Hz)
//   reset_i        asynchronous active-high reset
//   enable_i       decoder enable; low forces resynchronisation
//   di_i           NeoPixel data line (asynchronous, synchronised here)
//   busy_o         high while a frame is being decoded
//   pixel_valid_o  one-cycle strobe: new pixel on red/green/blue/address
//   address_o      0-based index of the presented pixel
//   red_o          decoded red byte
//   green_o        decoded green byte
//   blue_o         decoded blue byte
//   frame_done_o   one-cycle strobe at the end of the reset gap
//   pixel_count_o  complete pixels in the last frame (saturates at NUM_LEDS)
//   error_o        one-cycle timing-error strobe (0 without WS2812_RX_ERR_EN)

`timescale 1ns/1ps

module ws2812_rx #(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50_000_000,
    parameter int RESET_US     = 50
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          di_i,
    output logic                          busy_o,
    output logic                          pixel_valid_o,
    output logic [$clog2(NUM_LEDS)-1:0]   address_o,
    output logic [7:0]                    red_o,
    output logic [7:0]                    green_o,
    output logic [7:0]                    blue_o,
    output logic                          frame_done_o,
    output logic [$clog2(NUM_LEDS+1)-1:0] pixel_count_o,
    output logic                          error_o
);

    localparam int BIT_CYCLES  = SYSTEM_CLOCK / 800_000;
    localparam int THRESH      = (BIT_CYCLES * 45) / 100;
    localparam int RESET_COUNT = (SYSTEM_CLOCK / 1_000_000) * RESET_US;

    localparam int AW = $clog2(NUM_LEDS);
    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int CW = $clog2(RESET_COUNT + 1);

    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
    localparam logic [CW-1:0] RC_LAST_C = CW'(RESET_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
    localparam logic [PW-1:0] LEDS_C    = PW'(NUM_LEDS);

`ifdef WS2812_RX_ERR_EN
    localparam int MIN_HIGH = BIT_CYCLES / 8;
    localparam int MAX_HIGH = (BIT_CYCLES * 85) / 100;
    localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH);
    localparam logic [CW-1:0] MAX_HIGH_C = CW'(MAX_HIGH);
`endif

    typedef enum logic [1:0] {
        SYNC,   // waiting for a full reset gap before trusting the line
        READY,  // gap seen, waiting for the first rising edge of a frame
        HIGH,   // timing a high pulse
        LOW     // timing the low time after a bit
    } state_t;

    state_t          state;
    logic [1:0]      sync_q;      // two-flop synchroniser for di_i
    logic            s_d;         // synchronised line delayed one cycle
    logic            s;
    logic            rise;
    logic            fall;
    logic [CW-1:0]   cnt;         // shared high/low/gap cycle counter
    logic [4:0]      bit_cnt;     // bits of the current pixel
    logic [23:0]     shift_q;     // GRB bits, MSB first
    logic [PW-1:0]   pix_idx;     // complete pixels this frame, saturating
    logic            pix_pend;    // 24th bit just landed; present it next cycle
    logic            bit_seen;    // at least one bit decoded this frame

    assign s    = sync_q[1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    assign busy_o = (state == HIGH) || (state == LOW);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b00;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], di_i};
            s_d    <= sync_q[1];
        end
    end

    // NOTE: every register below is assigned with <= so that all branches see
    // the values from the start of the cycle; later assignments in the block
    // simply override earlier defaults within the same edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= SYNC;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift_q       <= '0;
            pix_idx       <= '0;
            pix_pend      <= 1'b0;
            bit_seen      <= 1'b0;
            pixel_valid_o <= 1'b0;
            address_o     <= '0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            frame_done_o  <= 1'b0;
            pixel_count_o <= '0;
`ifdef WS2812_RX_ERR_EN
            error_o       <= 1'b0;
`endif
        end else begin
            // Strobes default low; they are raised for exactly one cycle below.
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
`ifdef WS2812_RX_ERR_EN
            error_o       <= 1'b0;
`endif
            if (!enable_i) begin
                state    <= SYNC;
                cnt      <= '0;
                bit_cnt  <= '0;
                pix_idx  <= '0;
                pix_pend <= 1'b0;
                bit_seen <= 1'b0;
            end else begin
                // A finished pixel is presented one cycle after its last bit.
                // The next bit cannot be classified before the cycle after
                // this one, so shift_q is still intact here.
                if (pix_pend) begin
                    pix_pend <= 1'b0;
                    if (pix_idx < LEDS_C) begin
                        pixel_valid_o <= 1'b1;
                        address_o     <= pix_idx[AW-1:0];
                        green_o       <= shift_q[23:16];
                        red_o         <= shift_q[15:8];
                        blue_o        <= shift_q[7:0];
                        pix_idx       <= pix_idx + 1'b1;
                    end
                end

                case (state)
                    SYNC: begin
                        // Only a full low gap proves we are between frames.
                        if (s) begin
                            cnt <= '0;
                        end else if (cnt == RC_LAST_C) begin
                            state <= READY;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    READY: begin
                        if (rise) begin
                            state <= HIGH;
                            cnt   <= CNT_ONE_C;
                        end
                    end

                    HIGH: begin
                        if (fall) begin
`ifdef WS2812_RX_ERR_EN
                            if (cnt < MIN_HIGH_C) begin
                                // Glitch: not a bit, keep timing the low.
                                error_o <= 1'b1;
                                state   <= LOW;
                                cnt     <= CNT_ONE_C;
                            end else if (cnt > MAX_HIGH_C) begin
                                // Over-long pulse: lose lock and resync.
                                error_o  <= 1'b1;
                                state    <= SYNC;
                                cnt      <= '0;
                                bit_cnt  <= '0;
                                pix_idx  <= '0;
                                bit_seen <= 1'b0;
                            end else
`endif
                            begin
                                shift_q  <= {shift_q[22:0], (cnt >= THRESH_C)};
                                bit_seen <= 1'b1;
                                state    <= LOW;
                                cnt      <= CNT_ONE_C;
                                if (bit_cnt == 5'd23) begin
                                    bit_cnt  <= '0;
                                    pix_pend <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end else if (cnt == RC_LAST_C) begin
                            // Line stuck high: abandon the frame.
`ifdef WS2812_RX_ERR_EN
                            error_o  <= 1'b1;
`endif
                            state    <= SYNC;
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            pix_idx  <= '0;
                            bit_seen <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    LOW: begin
                        if (rise) begin
                            state <= HIGH;
                            cnt   <= CNT_ONE_C;
                        end else if (cnt == RC_LAST_C) begin
                            // Reset gap: close the frame. A partial pixel
                            // is simply dropped by clearing bit_cnt.
                            if (bit_seen) begin
                                frame_done_o  <= 1'b1;
                                pixel_count_o <= pix_idx;
`ifdef WS2812_RX_ERR_EN
                                error_o       <= (bit_cnt != 5'd0);
`endif
                            end
                            state    <= READY;
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            pix_idx  <= '0;
                            bit_seen <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= SYNC;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifndef WS2812_RX_ERR_EN
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx -- directed, table-driven bench for ws2812_rx at default
// parameters (50 MHz, 8 LEDs, 50 us gap). Bits are 59 cycles long with
// 18-cycle (0) or 37-cycle (1) high time; gaps are 3000 cycles (60 us).

`timescale 1ns/1ps

module tb_ws2812_rx;

    localparam int NUM_LEDS = 8;
    localparam int GAP      = 3000;
    localparam int H0       = 18;
    localparam int H1       = 37;
    localparam int BITC     = 59;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       di_i;
    logic       busy_o;
    logic       pixel_valid_o;
    logic [2:0] address_o;
    logic [7:0] red_o;
    logic [7:0] green_o;
    logic [7:0] blue_o;
    logic       frame_done_o;
    logic [3:0] pixel_count_o;
    logic       error_o;

    ws2812_rx #(
        .NUM_LEDS     (NUM_LEDS),
        .SYSTEM_CLOCK (50_000_000),
        .RESET_US     (50)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .di_i          (di_i),
        .busy_o        (busy_o),
        .pixel_valid_o (pixel_valid_o),
        .address_o     (address_o),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .frame_done_o  (frame_done_o),
        .pixel_count_o (pixel_count_o),
        .error_o       (error_o)
    );

    always #10 clk_i = ~clk_i;

    // ---------------- scoreboard of observed strobes ----------------
    typedef struct {
        logic [2:0] addr;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        time        t;
    } strobe_t;

    strobe_t    strobes[$];
    int         fd_cnt  = 0;
    int         err_cnt = 0;
    int         err_fd  = 0;
    logic [3:0] last_pc = '0;
    time        last_fall = 0;

    always @(negedge clk_i) begin
        if (pixel_valid_o)
            strobes.push_back('{addr: address_o, r: red_o, g: green_o, b: blue_o, t: $time});
        if (frame_done_o) begin
            fd_cnt  = fd_cnt + 1;
            last_pc = pixel_count_o;
            if (error_o) err_fd = err_fd + 1;
        end
        if (error_o) err_cnt = err_cnt + 1;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] grb;
        logic [2:0]  exp_addr;
        logic [7:0]  exp_r;
        logic [7:0]  exp_g;
        logic [7:0]  exp_b;
    } vec_t;

    task automatic check_strobe(input string name, input int idx, input vec_t v);
        check({name, " present"}, 32'(strobes.size() > idx), 1);
        if (strobes.size() > idx) begin
            check({name, " addr"},  32'(strobes[idx].addr), 32'(v.exp_addr));
            check({name, " red"},   32'(strobes[idx].r),    32'(v.exp_r));
            check({name, " green"}, 32'(strobes[idx].g),    32'(v.exp_g));
            check({name, " blue"},  32'(strobes[idx].b),    32'(v.exp_b));
        end
    endtask

    // ---------------- line drivers (all start and end on a negedge) ----------------
    task automatic idle(input int n);
        di_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse(input int hi, input int lo);
        di_i = 1'b1;
        repeat (hi) @(negedge clk_i);
        di_i = 1'b0;
        last_fall = $time;
        repeat (lo) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(H1, BITC - H1);
        else   pulse(H0, BITC - H0);
    endtask

    task automatic send_pixel(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    // ---------------- stimulus ----------------
    vec_t main_v[3];
    vec_t ov_v[10];

    initial begin
        int base;
        int fd0;
        int err0;

        main_v[0] = '{grb: 24'h123456, exp_addr: 3'd0, exp_r: 8'h34, exp_g: 8'h12, exp_b: 8'h56};
        main_v[1] = '{grb: 24'h00FF80, exp_addr: 3'd1, exp_r: 8'hFF, exp_g: 8'h00, exp_b: 8'h80};
        main_v[2] = '{grb: 24'hA55A0F, exp_addr: 3'd2, exp_r: 8'h5A, exp_g: 8'hA5, exp_b: 8'h0F};

        ov_v[0] = '{grb: 24'h01F011, exp_addr: 3'd0, exp_r: 8'hF0, exp_g: 8'h01, exp_b: 8'h11};
        ov_v[1] = '{grb: 24'h02E122, exp_addr: 3'd1, exp_r: 8'hE1, exp_g: 8'h02, exp_b: 8'h22};
        ov_v[2] = '{grb: 24'h03D233, exp_addr: 3'd2, exp_r: 8'hD2, exp_g: 8'h03, exp_b: 8'h33};
        ov_v[3] = '{grb: 24'h04C344, exp_addr: 3'd3, exp_r: 8'hC3, exp_g: 8'h04, exp_b: 8'h44};
        ov_v[4] = '{grb: 24'h05B455, exp_addr: 3'd4, exp_r: 8'hB4, exp_g: 8'h05, exp_b: 8'h55};
        ov_v[5] = '{grb: 24'h06A566, exp_addr: 3'd5, exp_r: 8'hA5, exp_g: 8'h06, exp_b: 8'h66};
        ov_v[6] = '{grb: 24'h079677, exp_addr: 3'd6, exp_r: 8'h96, exp_g: 8'h07, exp_b: 8'h77};
        ov_v[7] = '{grb: 24'h088788, exp_addr: 3'd7, exp_r: 8'h87, exp_g: 8'h08, exp_b: 8'h88};
        ov_v[8] = '{grb: 24'h097899, exp_addr: 3'd7, exp_r: 8'h78, exp_g: 8'h09, exp_b: 8'h99};
        ov_v[9] = '{grb: 24'h0A69AA, exp_addr: 3'd7, exp_r: 8'h69, exp_g: 8'h0A, exp_b: 8'hAA};

        // ---- reset state ----
        reset_i  = 1'b1;
        enable_i = 1'b0;
        di_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst busy",        32'(busy_o), 0);
        check("rst pixel_valid", 32'(pixel_valid_o), 0);
        check("rst address",     32'(address_o), 0);
        check("rst colours",     32'({red_o, green_o, blue_o}), 0);
        check("rst frame_done",  32'(frame_done_o), 0);
        check("rst pixel_count", 32'(pixel_count_o), 0);
        check("rst error",       32'(error_o), 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        enable_i = 1'b1;

        // ---- main frame: three pixels ----
        idle(GAP);
        base = strobes.size();
        fd0  = fd_cnt;
        for (int i = 0; i < 3; i++) send_pixel(main_v[i].grb);
        check("main busy mid-frame", 32'(busy_o), 1);
        check("main last latency", 32'(strobes.size() > base + 2 ? strobes[base + 2].t - last_fall : 0), 80);
        idle(GAP);
        check("main strobes", 32'(strobes.size() - base), 3);
        for (int i = 0; i < 3; i++) check_strobe($sformatf("main px%0d", i), base + i, main_v[i]);
        check("main frame_done", 32'(fd_cnt - fd0), 1);
        check("main pixel_count", 32'(last_pc), 3);
        check("main busy after gap", 32'(busy_o), 0);
        check("main red held", 32'(red_o), 8'h5A);
        check("main no error", 32'(err_cnt), 0);

        // ---- enable rises mid-frame ----
        enable_i = 1'b0;
        base = strobes.size();
        fd0  = fd_cnt;
        for (int i = 0; i < 100; i++) send_bit(logic'(i % 3 == 0));
        enable_i = 1'b1;
        for (int i = 0; i < 50; i++) send_bit(logic'(i % 2 == 0));
        check("en no strobes mid-frame", 32'(strobes.size() - base), 0);
        check("en busy in sync", 32'(busy_o), 0);
        idle(GAP);
        check("en no frame_done on resync", 32'(fd_cnt - fd0), 0);
        send_pixel(24'h0FF0AA);
        idle(GAP);
        check("en strobes", 32'(strobes.size() - base), 1);
        check_strobe("en px0", base, '{grb: 24'h0FF0AA, exp_addr: 3'd0, exp_r: 8'hF0, exp_g: 8'h0F, exp_b: 8'hAA});
        check("en pixel_count", 32'(last_pc), 1);

        // ---- overflow: ten pixels into eight slots ----
        base = strobes.size();
        fd0  = fd_cnt;
        for (int i = 0; i < 10; i++) send_pixel(ov_v[i].grb);
        idle(GAP);
        check("ov strobes", 32'(strobes.size() - base), 8);
        for (int i = 0; i < 8; i++) check_strobe($sformatf("ov px%0d", i), base + i, ov_v[i]);
        check("ov pixel_count", 32'(last_pc), 8);
        check("ov frame_done", 32'(fd_cnt - fd0), 1);
        check("ov address held", 32'(address_o), 7);
        check("ov red held", 32'(red_o), 32'(ov_v[7].exp_r));

        // ---- 30 bits: one pixel plus a partial ----
        base = strobes.size();
        fd0  = fd_cnt;
        err0 = err_fd;
        send_pixel(24'hC3691E);
        for (int i = 0; i < 6; i++) send_bit(logic'(i % 2 == 0));
        idle(GAP);
        check("part strobes", 32'(strobes.size() - base), 1);
        check_strobe("part px0", base, '{grb: 24'hC3691E, exp_addr: 3'd0, exp_r: 8'h69, exp_g: 8'hC3, exp_b: 8'h1E});
        check("part frame_done", 32'(fd_cnt - fd0), 1);
        check("part pixel_count", 32'(last_pc), 1);
`ifdef WS2812_RX_ERR_EN
        check("part error with frame_done", 32'(err_fd - err0), 1);
`else
        check("part error with frame_done", 32'(err_fd - err0), 0);
`endif

        // ---- stuck high ----
        base = strobes.size();
        fd0  = fd_cnt;
        err0 = err_cnt;
        di_i = 1'b1;
        repeat (3000) @(negedge clk_i);
        check("stuck busy", 32'(busy_o), 0);
        check("stuck strobes", 32'(strobes.size() - base), 0);
`ifdef WS2812_RX_ERR_EN
        check("stuck error", 32'(err_cnt - err0), 1);
`else
        check("stuck error", 32'(err_cnt - err0), 0);
`endif
        idle(GAP);
        check("stuck no frame_done", 32'(fd_cnt - fd0), 0);
        send_pixel(24'h5AA53C);
        idle(GAP);
        check_strobe("stuck recover px0", base, '{grb: 24'h5AA53C, exp_addr: 3'd0, exp_r: 8'hA5, exp_g: 8'h5A, exp_b: 8'h3C});
        check("stuck recover pixel_count", 32'(last_pc), 1);

        // ---- malformed pulse widths ----
        base = strobes.size();
        err0 = err_cnt;
`ifdef WS2812_RX_ERR_EN
        // 4-cycle glitch inside the green byte is ignored.
        for (int i = 23; i >= 0; i--) begin
            send_bit(logic'(((24'h814224 >> i) & 24'h1) != 0));
            if (i == 20) pulse(4, 55);
        end
        idle(GAP);
        check("glitch strobes", 32'(strobes.size() - base), 1);
        check_strobe("glitch px0", base, '{grb: 24'h814224, exp_addr: 3'd0, exp_r: 8'h42, exp_g: 8'h81, exp_b: 8'h24});
        check("glitch error", 32'(err_cnt - err0), 1);
        // 55-cycle pulse loses lock until a fresh gap.
        base = strobes.size();
        fd0  = fd_cnt;
        pulse(55, 4);
        send_pixel(24'hFFFFFF);
        idle(GAP);
        check("long strobes", 32'(strobes.size() - base), 0);
        check("long no frame_done", 32'(fd_cnt - fd0), 0);
        check("long error", 32'(err_cnt - err0), 2);
        check("total errors", 32'(err_cnt), 4);
`else
        // Without error checking, a 4-cycle pulse reads 0 and a 55-cycle one 1.
        for (int i = 23; i >= 0; i--) begin
            if (i == 20)      pulse(4, 55);
            else if (i == 10) pulse(55, 4);
            else              send_bit(logic'(((24'h814224 >> i) & 24'h1) != 0));
        end
        idle(GAP);
        check("width strobes", 32'(strobes.size() - base), 1);
        check_strobe("width px0", base, '{grb: 24'h814624, exp_addr: 3'd0, exp_r: 8'h46, exp_g: 8'h81, exp_b: 8'h24});
        check("total errors", 32'(err_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
